// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit owning the architectural HI/LO
// registers. It uses a shift-add multiply and a restoring divide, and both run
// on operand magnitudes. A final FIX cycle applies the sign correction and
// writes HI/LO.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-low reset
//   start     operation request, sampled only while busy=0
//   op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   src_a     multiplicand / dividend / MTHI-MTLO data
//   src_b     multiplier / divisor
//   busy      multiply/divide in progress
//   done      one-cycle pulse when HI/LO hold a new result
//   div_zero  one-cycle pulse with done for a divide by zero
//   hi, lo    HI/LO registers
module mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  // MUL: {partial product high, remaining multiplier bits}
  // DIV: {partial remainder, dividend bits shifting out / quotient shifting in}
  logic [2*W-1:0]  acc;
  logic [W-1:0]    opnd;      // multiplicand or divisor magnitude
  logic [W-1:0]    a_raw;     // raw dividend, returned in HI on divide by zero
  logic            is_div;
  logic            neg_lo;    // product sign or quotient sign
  logic            neg_hi;    // remainder sign
  logic            zero_div;

  logic            sign_a;
  logic            sign_b;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic [W:0]      mul_sum;
  logic [W:0]      div_diff;
  logic [2*W-1:0]  prod_fix;

  // Operand magnitudes at capture and the per-iteration datapath
  always_comb begin
    sign_a   = 1'b0;
    sign_b   = 1'b0;
    mag_a    = src_a;
    mag_b    = src_b;
    mul_sum  = '0;
    div_diff = '0;
    prod_fix = acc;
    // op[0]=0 selects the signed variants
    sign_a   = ~op[0] & src_a[W-1];
    sign_b   = ~op[0] & src_b[W-1];
    if (sign_a) mag_a = -src_a;
    if (sign_b) mag_b = -src_b;
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
    // Trial subtract of the left-shifted remainder
    div_diff = acc[2*W-1:W-1] - {1'b0, opnd};
    if (neg_lo) prod_fix = -acc;
  end

  // Control and datapath state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      zero_div <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (op)
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              OP_MULT, OP_MULTU: begin
                state  <= MUL;
                busy   <= 1'b1;
                cnt    <= '0;
                is_div <= 1'b0;
                acc    <= {{W{1'b0}}, mag_b};
                opnd   <= mag_a;
                a_raw  <= src_a;
                neg_lo <= sign_a ^ sign_b;
                neg_hi <= sign_a ^ sign_b;
                zero_div <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                state  <= DIV;
                busy   <= 1'b1;
                cnt    <= '0;
                is_div <= 1'b1;
                acc    <= {{W{1'b0}}, mag_a};
                opnd   <= mag_b;
                a_raw  <= src_a;
                neg_lo <= sign_a ^ sign_b;
                neg_hi <= sign_a;
                zero_div <= (src_b == '0);
              end
              default: ;  // reserved encodings are ignored
            endcase
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[W-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        DIV: begin
          if (!div_diff[W]) acc <= {div_diff[W-1:0], acc[W-2:0], 1'b1};
          else              acc <= {acc[2*W-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[2*W-1:W];
            lo <= prod_fix[W-1:0];
          end else if (zero_div) begin
            // Divide by zero returns the raw dividend with no sign fixup
            hi       <= a_raw;
            lo       <= '1;
            div_zero <= 1'b1;
          end else begin
            hi <= neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
            lo <= neg_lo ? -acc[W-1:0]   : acc[W-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
